// File: rtl/vga_sync_if.sv
// Timing outputs of the VGA sync generator: sync pulses, visible flag,
// current coordinate and line/frame strobes, all registered and mutually aligned.
interface vga_sync_if #(
    parameter int CNT_W = 10
);
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;

    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        input hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical timing generator for the VGA pixel clock domain.
// Every output is decoded from the next counter values and registered.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CNT_W     = 10
) (
    input  logic       clk_25,
    input  logic       rst,
    vga_sync_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    logic hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;
    logic hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

    always_comb begin
        h_next = h_cnt + CNT_W'(1);
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end

        // Decode the coordinate that will be on pixel_x/pixel_y after this edge.
        hsync_d       = !((h_next >= HS_START) && (h_next < HS_END));
        vsync_d       = !((v_next >= VS_START) && (v_next < VS_END));
        video_on_d    = (h_next < H_VIS) && (v_next < V_VIS);
        line_start_d  = (h_next == '0);
        frame_start_d = (h_next == '0) && (v_next == '0);
    end

    // Reset parks on the last coordinate of a frame so release starts at (0,0).
    always_ff @(posedge clk_25) begin
        if (rst) begin
            h_cnt         <= H_LAST;
            v_cnt         <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt         <= h_next;
            v_cnt         <= v_next;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_x     = h_cnt;
    assign vga.pixel_y     = v_cnt;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing plus a tiny 16x8 configuration
// that makes full-frame behaviour reachable in a few hundred cycles.
module tb_vga_sync_gen;
    logic clk_25 = 1'b0;
    logic rst;
    logic rst_s;

    always #20 clk_25 = ~clk_25;

    int checks = 0;
    int errors = 0;

    vga_sync_if #(.CNT_W(10)) vga_d ();
    vga_sync_if #(.CNT_W(4))  vga_s ();

    vga_sync_gen dut_d (
        .clk_25 (clk_25),
        .rst    (rst),
        .vga    (vga_d)
    );

    vga_sync_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .CNT_W     (4)
    ) dut_s (
        .clk_25 (clk_25),
        .rst    (rst_s),
        .vga    (vga_s)
    );

    int ex, ey, bad, prev_hs, prev_vs;
    int fall_x, rise_x, hs_low, vs_low, vid, ls_n, fs_n, fs_at;
    int vs_fall_x, vs_fall_y, vs_rise_x, vs_rise_y;
    logic e_hs, e_vs, e_vid, e_ls, e_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input int x, input int y, input logic hs,
                         input logic vs, input logic vo, input logic ls, input logic fs);
        chk({tag, "/x"}, 32'(vga_d.pixel_x), 32'(x));
        chk({tag, "/y"}, 32'(vga_d.pixel_y), 32'(y));
        chk({tag, "/hsync"}, 32'(vga_d.hsync), 32'(hs));
        chk({tag, "/vsync"}, 32'(vga_d.vsync), 32'(vs));
        chk({tag, "/video_on"}, 32'(vga_d.video_on), 32'(vo));
        chk({tag, "/line_start"}, 32'(vga_d.line_start), 32'(ls));
        chk({tag, "/frame_start"}, 32'(vga_d.frame_start), 32'(fs));
    endtask

    task automatic chk_s(input string tag, input int x, input int y, input logic hs,
                         input logic vs, input logic vo, input logic ls, input logic fs);
        chk({tag, "/x"}, 32'(vga_s.pixel_x), 32'(x));
        chk({tag, "/y"}, 32'(vga_s.pixel_y), 32'(y));
        chk({tag, "/hsync"}, 32'(vga_s.hsync), 32'(hs));
        chk({tag, "/vsync"}, 32'(vga_s.vsync), 32'(vs));
        chk({tag, "/video_on"}, 32'(vga_s.video_on), 32'(vo));
        chk({tag, "/line_start"}, 32'(vga_s.line_start), 32'(ls));
        chk({tag, "/frame_start"}, 32'(vga_s.frame_start), 32'(fs));
    endtask

    initial begin
        rst   = 1'b1;
        rst_s = 1'b1;

        // Default timing: reset hold and release.
        repeat (5) @(negedge clk_25);
        chk_d("d_rst_hold", 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk_25);
        chk_d("d_release", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // One full line.
        ex = 0; ey = 0; bad = 0; prev_hs = 1;
        fall_x = -1; rise_x = -1; hs_low = 0; vid = 0; ls_n = 0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk_25);
            ex = (ex == 799) ? 0 : ex + 1;
            if (ex == 0) ey++;
            if (vga_d.pixel_x !== 10'(ex) || vga_d.pixel_y !== 10'(ey)) bad++;
            if (prev_hs == 1 && vga_d.hsync === 1'b0) fall_x = int'(vga_d.pixel_x);
            if (prev_hs == 0 && vga_d.hsync === 1'b1) rise_x = int'(vga_d.pixel_x);
            prev_hs = (vga_d.hsync === 1'b1) ? 1 : 0;
            if (vga_d.hsync === 1'b0) hs_low++;
            if (vga_d.video_on === 1'b1) vid++;
            if (vga_d.line_start === 1'b1) ls_n++;
        end
        chk("d_coord_track", 32'(bad), 32'd0);
        chk("d_hsync_fall_x", 32'(fall_x), 32'd656);
        chk("d_hsync_rise_x", 32'(rise_x), 32'd752);
        chk("d_hsync_low_clks", 32'(hs_low), 32'd96);
        chk("d_video_per_line", 32'(vid), 32'd640);
        chk("d_line_start_count", 32'(ls_n), 32'd1);
        chk_d("d_line1", 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Advance to the end of line 10 and across into line 11.
        repeat (7999) @(negedge clk_25);
        chk_d("d_x799_y10", 799, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk_25);
        chk_d("d_x0_y11", 0, 11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (639) @(negedge clk_25);
        chk_d("d_x639_y11", 639, 11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk_25);
        chk_d("d_x640_y11", 640, 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an hsync pulse.
        repeat (60) @(negedge clk_25);
        chk_d("d_x700_y11", 700, 11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk_25);
        chk_d("d_mid_rst", 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk_25);
        chk_d("d_mid_release", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Small timing: 16 clocks per line, 8 lines per frame.
        chk_s("s_rst_hold", 15, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_s = 1'b0;
        @(negedge clk_25);
        chk_s("s_release", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        ex = 0; ey = 0; bad = 0; prev_vs = 1;
        hs_low = 0; vs_low = 0; vid = 0; fs_n = 0; fs_at = -1;
        vs_fall_x = -1; vs_fall_y = -1; vs_rise_x = -1; vs_rise_y = -1;
        for (int i = 1; i <= 128; i++) begin
            @(negedge clk_25);
            ex = (ex == 15) ? 0 : ex + 1;
            if (ex == 0) ey = (ey == 7) ? 0 : ey + 1;
            e_hs  = !(ex >= 10 && ex <= 12);
            e_vs  = !(ey >= 5 && ey <= 6);
            e_vid = (ex < 8) && (ey < 4);
            e_ls  = (ex == 0);
            e_fs  = (ex == 0) && (ey == 0);
            if (vga_s.pixel_x !== 4'(ex) || vga_s.pixel_y !== 4'(ey) ||
                vga_s.hsync !== e_hs || vga_s.vsync !== e_vs || vga_s.video_on !== e_vid ||
                vga_s.line_start !== e_ls || vga_s.frame_start !== e_fs) bad++;
            if (vga_s.hsync === 1'b0) hs_low++;
            if (vga_s.vsync === 1'b0) vs_low++;
            if (vga_s.video_on === 1'b1) vid++;
            if (vga_s.frame_start === 1'b1) begin
                fs_n++;
                if (fs_at < 0) fs_at = i;
            end
            if (prev_vs == 1 && vga_s.vsync === 1'b0) begin
                vs_fall_x = int'(vga_s.pixel_x);
                vs_fall_y = int'(vga_s.pixel_y);
            end
            if (prev_vs == 0 && vga_s.vsync === 1'b1) begin
                vs_rise_x = int'(vga_s.pixel_x);
                vs_rise_y = int'(vga_s.pixel_y);
            end
            prev_vs = (vga_s.vsync === 1'b1) ? 1 : 0;
        end
        chk("s_decode_track", 32'(bad), 32'd0);
        chk("s_frame_period", 32'(fs_at), 32'd128);
        chk("s_frame_start_count", 32'(fs_n), 32'd1);
        chk("s_hsync_low_clks", 32'(hs_low), 32'd24);
        chk("s_vsync_low_clks", 32'(vs_low), 32'd32);
        chk("s_video_per_frame", 32'(vid), 32'd32);
        chk("s_vsync_fall_x", 32'(vs_fall_x), 32'd0);
        chk("s_vsync_fall_y", 32'(vs_fall_y), 32'd5);
        chk("s_vsync_rise_x", 32'(vs_rise_x), 32'd0);
        chk("s_vsync_rise_y", 32'(vs_rise_y), 32'd7);
        chk_s("s_frame_wrap", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Small timing: reset mid-frame.
        repeat (53) @(negedge clk_25);
        chk_s("s_x5_y3", 5, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_s = 1'b1;
        @(negedge clk_25);
        chk_s("s_mid_rst", 15, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_s = 1'b0;
        @(negedge clk_25);
        chk_s("s_mid_release", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
